// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host-side request/response bundle for spi_master_ctrl
//
// Signals:
//   start  request strobe (host -> controller)
//   cmd    command byte: 0x01 read, 0x02 write, 0x03 replace
//   wdata  byte shifted to the slave in the data phase
//   busy   controller is not accepting requests
//   done   one-cycle pulse at frame end
//   err    one-cycle pulse when an illegal command is rejected
//   rdata  byte captured from the slave, held until the next done
// Modports: master = host logic, slave = spi_master_ctrl.
interface spi_master_ctrl_if;
  logic       start;
  logic [7:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rdata;

  modport master (
    output start, cmd, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  start, cmd, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - single-slave SPI frame sequencer (8 cmd bits + 8 data bits)
//
// Ports:
//   clk, rst   system clock shared with the slave; async active-high reset
//   host       spi_master_ctrl_if.slave request/response bundle
//   CS         slave chip select, active low
//   SDI        serial data to the slave, MSB first
//   SDO        serial data from the slave
//   shadow     (SPI_SHADOW_EN) expected slave memory contents
//   mismatch   (SPI_SHADOW_EN) one-cycle pulse when a read disagrees with shadow
// Parameter GAP_CYCLES: cycles CS stays high after a frame before the next request (min 1).
// Optional feature macro: SPI_SHADOW_EN.
module spi_master_ctrl #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  spi_master_ctrl_if.slave host,
  output logic CS,
  output logic SDI,
  input  logic SDO
`ifdef SPI_SHADOW_EN
  ,
  output logic [7:0] shadow,
  output logic       mismatch
`endif
);

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, GAP} state_t;

  state_t        state, state_d;
  // Remaining frame bits after the one currently on SDI; bit 14 is always next.
  logic [14:0]   tx, tx_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          cs_d, sdi_d, busy_d, done_d, err_d;
  logic [7:0]    rdata_d;
  logic          cmd_ok;

`ifdef SPI_SHADOW_EN
  logic [7:0] cmd_q, cmd_q_d, wdata_q, wdata_q_d, shadow_d;
  logic       mismatch_d;
`endif

  assign cmd_ok = (host.cmd == 8'h01) || (host.cmd == 8'h02) || (host.cmd == 8'h03);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      CS         <= 1'b1;
      SDI        <= 1'b0;
      host.busy  <= 1'b0;
      host.done  <= 1'b0;
      host.err   <= 1'b0;
      host.rdata <= 8'h00;
`ifdef SPI_SHADOW_EN
      cmd_q      <= 8'h00;
      wdata_q    <= 8'h00;
      shadow     <= 8'hC8;
      mismatch   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      tx         <= tx_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      CS         <= cs_d;
      SDI        <= sdi_d;
      host.busy  <= busy_d;
      host.done  <= done_d;
      host.err   <= err_d;
      host.rdata <= rdata_d;
`ifdef SPI_SHADOW_EN
      cmd_q      <= cmd_q_d;
      wdata_q    <= wdata_q_d;
      shadow     <= shadow_d;
      mismatch   <= mismatch_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    tx_d      = tx;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    cs_d      = CS;
    sdi_d     = SDI;
    busy_d    = host.busy;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = host.rdata;
`ifdef SPI_SHADOW_EN
    cmd_q_d    = cmd_q;
    wdata_q_d  = wdata_q;
    shadow_d   = shadow;
    mismatch_d = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (host.start) begin
          if (cmd_ok) begin
            state_d   = CMD;
            sdi_d     = host.cmd[7];
            tx_d      = {host.cmd[6:0], host.wdata};
            cs_d      = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
`ifdef SPI_SHADOW_EN
            cmd_q_d   = host.cmd;
            wdata_q_d = host.wdata;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CMD: begin
        // Slave samples the current bit on this edge; present the next one.
        sdi_d     = tx[14];
        tx_d      = {tx[13:0], 1'b0};
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_d = DATA;
      end

      DATA: begin
        sdi_d     = tx[14];
        tx_d      = {tx[13:0], 1'b0};
        rdata_d   = {host.rdata[6:0], SDO};
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          // 16th edge: the frame is complete, CS may now rise.
          state_d   = GAP;
          cs_d      = 1'b1;
          sdi_d     = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = '0;
`ifdef SPI_SHADOW_EN
          if (cmd_q == 8'h01) mismatch_d = ({host.rdata[6:0], SDO} != shadow);
          else                shadow_d   = wdata_q;
`endif
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl with an 8-bit slave model
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic CS, SDI, SDO;
`ifdef SPI_SHADOW_EN
  logic [7:0] shadow;
  logic       mismatch;
`endif

  spi_master_ctrl_if bus();

  spi_master_ctrl #(.GAP_CYCLES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .CS   (CS),
    .SDI  (SDI),
    .SDO  (SDO)
`ifdef SPI_SHADOW_EN
    ,
    .shadow   (shadow),
    .mismatch (mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Slave model: 8 cmd bits shifted in, then 8 data edges that rotate (read)
  // or shift SDI into memory (write/replace). SDO always shows memory bit 7.
  logic [7:0] mem = 8'hC8;
  logic [7:0] s_cmd = 8'h00;
  int         s_cnt = 0;
  assign SDO = mem[7];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt <= 0;
    end else if (!CS) begin
      if (s_cnt < 8) s_cmd <= {s_cmd[6:0], SDI};
      else if (s_cmd == 8'h01) mem <= {mem[6:0], mem[7]};
      else mem <= {mem[6:0], SDI};
      s_cnt <= (s_cnt == 15) ? 0 : s_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  f_rd;
  logic [15:0] f_sdi;
  int          f_cs, f_done, f_gap;
  logic        f_ok, f_mism;

  task automatic do_frame(input logic [7:0] c, input logic [7:0] w, input bit hold);
    bit seen_done;
    f_rd = 8'h00; f_sdi = 16'h0; f_cs = 0; f_done = 0; f_gap = 0;
    f_ok = 1'b0; f_mism = 1'b0; seen_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = c; bus.wdata = w;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!CS) begin
        f_cs++;
        f_sdi = {f_sdi[14:0], SDI};
      end
      if (bus.done) begin
        f_done++;
        f_rd = bus.rdata;
        seen_done = 1'b1;
`ifdef SPI_SHADOW_EN
        f_mism = mismatch;
`endif
      end
      if (seen_done && !bus.busy) begin
        f_ok = 1'b1;
        break;
      end
      if (seen_done) f_gap++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("frame_complete", f_ok, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.cmd = 8'h00; bus.wdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs", CS, 1);
    check("rst_sdi", SDI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rdata", bus.rdata, 8'h00);

    // Power-up read
    do_frame(8'h01, 8'h00, 1'b0);
    check("rd0_cs_low", f_cs, 16);
    check("rd0_done", f_done, 1);
    check("rd0_rdata", f_rd, 8'hC8);
    check("rd0_sdi", f_sdi, 16'h0100);
    check("rd0_gap", f_gap, 2);
`ifdef SPI_SHADOW_EN
    check("rd0_mismatch", f_mism, 0);
`endif

    // Write 0x5A, then read it back
    do_frame(8'h02, 8'h5A, 1'b0);
    check("wr_rdata_old", f_rd, 8'hC8);
    check("wr_sdi", f_sdi, 16'h025A);
    check("wr_cs_low", f_cs, 16);
`ifdef SPI_SHADOW_EN
    check("wr_shadow", shadow, 8'h5A);
`endif
    do_frame(8'h01, 8'h00, 1'b0);
    check("rd1_rdata", f_rd, 8'h5A);
`ifdef SPI_SHADOW_EN
    check("rd1_mismatch", f_mism, 0);
`endif

    // Replace with 0x3C, then read
    do_frame(8'h03, 8'h3C, 1'b0);
    check("rep_rdata_old", f_rd, 8'h5A);
    check("rep_sdi", f_sdi, 16'h033C);
    do_frame(8'h01, 8'h00, 1'b0);
    check("rd2_rdata", f_rd, 8'h3C);

    // Illegal command
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 8'h07; bus.wdata = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    check("ill_err", bus.err, 1);
    check("ill_cs", CS, 1);
    check("ill_busy", bus.busy, 0);
    check("ill_rdata", bus.rdata, 8'h3C);
    @(negedge clk);
    check("ill_err_pulse", bus.err, 0);
    check("ill_cs_after", CS, 1);

    // start held high for the whole frame: one frame only
    do_frame(8'h01, 8'h00, 1'b1);
    check("spam_done", f_done, 1);
    check("spam_cs_low", f_cs, 16);
    check("spam_gap", f_gap, 2);
    check("spam_rdata", f_rd, 8'h3C);
    repeat (3) @(negedge clk);
    check("spam_no_second", CS, 1);

    // Reset in the middle of the command phase
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 8'h02; bus.wdata = 8'hAA;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_cs_low", CS, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cs", CS, 1);
    check("mid_rst_sdi", SDI, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_rdata", bus.rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_frame(8'h01, 8'h00, 1'b0);
    check("post_rst_cs_low", f_cs, 16);
    check("post_rst_rdata", f_rd, 8'h3C);
`ifdef SPI_SHADOW_EN
    check("post_rst_mismatch", f_mism, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-slave SPI transaction controller that sequences the team's 8-bit SPI slave: accepts one request (command + write byte) from a local host and drives CS/SDI for one fixed 16-bit frame. Frame = 8 command bits then 8 data bits, MSB first. Returns the byte shifted out of the slave.
Sits between the host logic and the slave pins, sharing the slave's clk. Also enforces full-length frames, since the slave's bit counter is not resettable.

Parameters:
GAP_CYCLES, 2, clk cycles CS held high after each frame before the next request is accepted (min 1)

Ports:
clk  input  1  system clock, shared with slave
rst  input  1  asynchronous, active-high reset
start  input  1  request strobe, sampled only in IDLE
cmd  input  8  command byte: 0x01 read, 0x02 write, 0x03 replace
wdata  input  8  byte shifted to slave in data phase
busy  output  1  high while a request is not being accepted
done  output  1  one-cycle pulse at frame end
err  output  1  one-cycle pulse when an illegal command is rejected
rdata  output  8  byte captured from slave in data phase, held until next done
CS  output  1  slave chip select, active low
SDI  output  1  serial data to slave
SDO  input  1  serial data from slave

Behaviour:
- One clock (clk), async active-high reset (rst). All state updates on posedge clk.
- Reset values: CS=1, SDI=0, busy=0, done=0, err=0, rdata=0x00, state=IDLE, counters=0.
- FSM states: IDLE, CMD, DATA, GAP.
- IDLE, start=1 and cmd in {0x01,0x02,0x03}:
  - Latch cmd and wdata.
  - Next cycle: CS=0, SDI=cmd[7], busy=1; enter CMD.
- IDLE, start=1 with any other cmd:
  - err=1 for one cycle; CS stays 1; remain IDLE; busy stays 0.
- CMD (8 cycles):
  - At each posedge the slave samples SDI; controller then presents the next cmd bit.
  - After the 8th CMD edge: SDI=wdata[7]; enter DATA.
- DATA (8 cycles):
  - At each posedge the controller shifts SDO into rdata LSB (rdata <= {rdata[6:0],SDO}) and presents the next wdata bit on SDI.
  - First sample is slave memory bit 7.
- Frame end, after the 8th DATA edge (16 edges with CS=0 in total):
  - CS=1, SDI=0.
  - done=1 for exactly one cycle; rdata final.
  - Enter GAP.
- GAP: CS=1 for GAP_CYCLES cycles, then IDLE with busy=0. Total request-to-idle latency is 17+GAP_CYCLES cycles.
- start while busy=1 is ignored: no queueing, no err.
- CS is never deasserted mid-frame except by rst. This is mandatory because the slave counter only realigns on 16-edge boundaries.
- rst mid-frame: all outputs return to reset values immediately (async). Slave alignment after a mid-frame reset is not recoverable by this block; the system-level reset must cover both.
- Illegal-command check uses only the latched start-cycle value of cmd.
- Command effects on slave memory:
  - Read: memory rotates 8 times and ends unchanged; rdata = memory.
  - Write: memory = wdata; rdata = old memory (the rotated-out bits).
  - Replace: memory = wdata; rdata = old memory.

Optional Feature:
Macro SPI_SHADOW_EN.
- Defined:
  - Adds outputs shadow[7:0] and mismatch (1).
  - shadow resets to 0xC8, the slave's power-up contents.
  - On done for write or replace: shadow = latched wdata.
  - On done for read: mismatch pulses for one cycle when rdata != shadow; shadow is unchanged.
- Not defined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset then read (cmd=0x01, wdata=0x00) -> CS low exactly 16 cycles, done one pulse, rdata=0xC8; with SPI_SHADOW_EN, mismatch=0.
- Write cmd=0x02 wdata=0x5A, then read -> second rdata=0x5A; SDI during write frame = 00000010 01011010 MSB first.
- Replace cmd=0x03 wdata=0x3C with slave holding 0x5A -> rdata=0x5A; following read returns 0x3C.
- Illegal cmd=0x07 with start=1 in IDLE -> err one-cycle pulse, CS stays 1, busy 0, rdata unchanged.
- start pulsed every cycle during a frame -> exactly one frame; busy low GAP_CYCLES (2) cycles after done before the next frame's CS falls.
- rst asserted at CMD bit 4 -> CS=1, busy=0, done=0, rdata=0x00 in same cycle; controller idle and accepts start after rst release.
